mmc_cmd_seq: RTL and testbench

MMC_CMD_SEQ -- requirements
Module: mmc_cmd_seq

---
 rtl/mmc_cmd_seq.sv | 157 +++++++++++++++
 tb/tb_mmc_cmd_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmc_cmd_seq.sv
// MMC command-line sequencer: sends a 48-bit command frame with CRC7, optionally
// receives a 48-bit response, then clocks NRC trailing cycles before signalling done.
module mmc_cmd_seq #(
    parameter int TIMEOUT = 64,
    parameter int NRC     = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    input  logic        resp_en,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        crc_err,
    output logic [5:0]  resp_idx,
    output logic [31:0] resp_arg,
    output logic        clk_tick,
    input  logic        clk_done,
    output logic        mmc_cmd_o,
    output logic        mmc_cmd_oe,
    input  logic        mmc_cmd_i
);

    typedef enum logic [2:0] {IDLE, TX, RESP_WAIT, RX, TRAIL, FIN} state_t;

    localparam int CMAX_A = (TIMEOUT > 48) ? TIMEOUT : 48;
    localparam int CMAX   = (CMAX_A > NRC) ? CMAX_A : NRC;
    localparam int CW     = $clog2(CMAX + 1);

    // CRC7, polynomial x^7+x^3+1, zero seed, over 40 bits MSB first
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    state_t         state_reg, state_next;
    logic           pending_reg;
    logic           clk_tick_reg;
    logic [CW-1:0]  cnt_reg;
    logic [47:0]    tx_shift_reg;
    logic [46:0]    rx_shift_reg;
    logic           resp_en_reg;
    logic           timeout_reg;
    logic           crc_err_reg;
    logic [5:0]     resp_idx_reg;
    logic [31:0]    resp_arg_reg;

    logic           bit_active;
    logic           bit_evt;
    logic [47:0]    rx_full;
    logic           rx_bad;
    logic           tx_last, wait_last, rx_last, trail_last;

    // A clk_done only counts when it answers our own outstanding tick
    assign bit_evt    = pending_reg & clk_done;
    assign bit_active = (state_reg == TX) || (state_reg == RESP_WAIT) ||
                        (state_reg == RX) || (state_reg == TRAIL);
    assign rx_full    = {rx_shift_reg, mmc_cmd_i};
    assign rx_bad     = rx_full[46] | ~rx_full[0] | (rx_full[7:1] != crc7(rx_full[47:8]));
    assign tx_last    = (cnt_reg == CW'(47));
    assign wait_last  = (cnt_reg == CW'(TIMEOUT - 1));
    assign rx_last    = (cnt_reg == CW'(46));
    assign trail_last = (cnt_reg == CW'(NRC - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (start) state_next = TX;
            TX:        if (bit_evt && tx_last) state_next = resp_en_reg ? RESP_WAIT : TRAIL;
            RESP_WAIT: if (bit_evt) begin
                           if (!mmc_cmd_i)     state_next = RX;
                           else if (wait_last) state_next = TRAIL;
                       end
            RX:        if (bit_evt && rx_last) state_next = TRAIL;
            TRAIL:     if (bit_evt && trail_last) state_next = FIN;
            FIN:       state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_reg != IDLE) && (state_reg != FIN);
        done       = (state_reg == FIN);
        mmc_cmd_oe = (state_reg == TX);
        mmc_cmd_o  = mmc_cmd_oe ? tx_shift_reg[47] : 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pending_reg  <= 1'b0;
            clk_tick_reg <= 1'b0;
            cnt_reg      <= '0;
            tx_shift_reg <= '1;
            rx_shift_reg <= '0;
            resp_en_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
            crc_err_reg  <= 1'b0;
            resp_idx_reg <= '0;
            resp_arg_reg <= '0;
        end else begin
            clk_tick_reg <= 1'b0;
            if (bit_active && !pending_reg) begin
                clk_tick_reg <= 1'b1;
                pending_reg  <= 1'b1;
            end else if (bit_evt) begin
                pending_reg  <= 1'b0;
            end

            if (state_next != state_reg) cnt_reg <= '0;
            else if (bit_evt)            cnt_reg <= cnt_reg + 1'b1;

            case (state_reg)
                IDLE: if (start) begin
                    tx_shift_reg <= {2'b01, cmd_idx, cmd_arg, crc7({2'b01, cmd_idx, cmd_arg}), 1'b1};
                    resp_en_reg  <= resp_en;
                    timeout_reg  <= 1'b0;
                    crc_err_reg  <= 1'b0;
                end
                TX: if (bit_evt) tx_shift_reg <= {tx_shift_reg[46:0], 1'b1};
                RESP_WAIT: if (bit_evt) begin
                    if (!mmc_cmd_i)     rx_shift_reg <= '0;
                    else if (wait_last) timeout_reg  <= 1'b1;
                end
                RX: if (bit_evt) begin
                    rx_shift_reg <= rx_full[46:0];
                    if (rx_last) begin
                        resp_idx_reg <= rx_full[45:40];
                        resp_arg_reg <= rx_full[39:8];
                        crc_err_reg  <= rx_bad;
                    end
                end
                default: ;
            endcase
        end
    end

    assign clk_tick = clk_tick_reg;
    assign timeout  = timeout_reg;
    assign crc_err  = crc_err_reg;
    assign resp_idx = resp_idx_reg;
    assign resp_arg = resp_arg_reg;

endmodule

// File: tb/tb_mmc_cmd_seq.sv
// Directed bench for mmc_cmd_seq with a card model answering each clk_tick.
module tb_mmc_cmd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  cmd_idx = '0;
    logic [31:0] cmd_arg = '0;
    logic        resp_en = 1'b0;
    logic        busy, done, timeout, crc_err;
    logic [5:0]  resp_idx;
    logic [31:0] resp_arg;
    logic        clk_tick;
    logic        clk_done = 1'b0;
    logic        mmc_cmd_o, mmc_cmd_oe;
    logic        mmc_cmd_i = 1'b1;

    mmc_cmd_seq #(.TIMEOUT(64), .NRC(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .cmd_idx(cmd_idx),
        .cmd_arg(cmd_arg), .resp_en(resp_en), .busy(busy), .done(done),
        .timeout(timeout), .crc_err(crc_err), .resp_idx(resp_idx),
        .resp_arg(resp_arg), .clk_tick(clk_tick), .clk_done(clk_done),
        .mmc_cmd_o(mmc_cmd_o), .mmc_cmd_oe(mmc_cmd_oe), .mmc_cmd_i(mmc_cmd_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    // card model state
    logic [47:0] tx_frame;
    logic [47:0] reply;
    logic        reply_on = 1'b0;
    logic        rand_delay = 1'b0;
    int tx_bits = 0, tick_cnt = 0, card_clk = 0, reply_pos = 0;
    int early_ticks = 0, unstable = 0, done_cnt = 0;

    always @(negedge clk) if (done) done_cnt++;

    initial begin : card
        int  d;
        logic held_o, held_oe;
        forever begin
            @(negedge clk);
            if (clk_tick) begin
                tick_cnt++;
                held_o  = mmc_cmd_o;
                held_oe = mmc_cmd_oe;
                if (!mmc_cmd_oe) begin
                    card_clk++;
                    if (reply_on && card_clk > 5 && reply_pos < 48) begin
                        mmc_cmd_i = reply[47 - reply_pos];
                        reply_pos++;
                    end else begin
                        mmc_cmd_i = 1'b1;
                    end
                end
                d = rand_delay ? int'($urandom_range(1, 10)) : 1;
                repeat (d) begin
                    @(negedge clk);
                    if (clk_tick) early_ticks++;
                end
                if (held_oe && mmc_cmd_oe) begin
                    if (mmc_cmd_o !== held_o) unstable++;
                    tx_frame = {tx_frame[46:0], mmc_cmd_o};
                    tx_bits++;
                end
                clk_done = 1'b1;
                @(negedge clk);
                clk_done  = 1'b0;
                mmc_cmd_i = 1'b1;
            end
        end
    end

    task automatic clear_model(input logic ron, input logic [47:0] rv, input logic rd);
        tx_frame = '0; tx_bits = 0; tick_cnt = 0; card_clk = 0; reply_pos = 0;
        reply_on = ron; reply = rv; rand_delay = rd;
        done_cnt = 0; early_ticks = 0; unstable = 0;
    endtask

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic re);
        @(negedge clk);
        cmd_idx = idx; cmd_arg = arg; resp_en = re; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int  n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20000) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            n++;
        end
        check(tag, seen, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_tx_bits(input string tag, input int target);
        int n;
        n = 0;
        while (tx_bits < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, tx_bits >= target, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_oe", mmc_cmd_oe, 0);
        check("rst_cmd_o", mmc_cmd_o, 1);
        check("rst_tick", clk_tick, 0);
        check("rst_flags", {timeout, crc_err}, 0);
        check("rst_resp", {resp_idx, resp_arg}, 0);
        rst = 1'b0;
        @(negedge clk);

        // CMD0, no response
        clear_model(1'b0, 48'h0, 1'b0);
        issue(6'd0, 32'h0, 1'b0);
        check("t1_busy", busy, 1);
        wait_done("t1_done_seen");
        check("t1_frame", tx_frame, 48'h400000000095);
        check("t1_ticks", tick_cnt, 56);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_flags", {timeout, crc_err}, 0);
        check("t1_busy_after", busy, 0);
        check("t1_stable", unstable, 0);

        // CMD8 with good reply after 5 idle clocks
        clear_model(1'b1, 48'h08000001AA13, 1'b0);
        issue(6'd8, 32'h000001AA, 1'b1);
        wait_done("t2_done_seen");
        check("t2_frame", tx_frame, 48'h48000001AA87);
        check("t2_resp_idx", resp_idx, 8);
        check("t2_resp_arg", resp_arg, 32'h000001AA);
        check("t2_flags", {timeout, crc_err}, 0);
        check("t2_ticks", tick_cnt, 109);
        check("t2_done_cnt", done_cnt, 1);

        // no response: timeout after 64 waits, 8 trailing
        clear_model(1'b0, 48'h0, 1'b0);
        issue(6'd55, 32'h0, 1'b1);
        wait_done("t3_done_seen");
        check("t3_timeout", timeout, 1);
        check("t3_crc_err", crc_err, 0);
        check("t3_released_clks", card_clk, 72);
        check("t3_ticks", tick_cnt, 120);
        check("t3_resp_kept", {resp_idx, resp_arg}, {6'd8, 32'h000001AA});

        // bad end bit
        clear_model(1'b1, 48'h08000001AA12, 1'b0);
        issue(6'd8, 32'h000001AA, 1'b1);
        wait_done("t4_done_seen");
        check("t4_crc_err", crc_err, 1);
        check("t4_timeout", timeout, 0);
        check("t4_resp_arg", resp_arg, 32'h000001AA);
        check("t4_done_cnt", done_cnt, 1);

        // bad CRC field, good end bit, different response index
        clear_model(1'b1, 48'h02000001AA15, 1'b0);
        issue(6'd8, 32'h000001AA, 1'b1);
        wait_done("t4b_done_seen");
        check("t4b_crc_err", crc_err, 1);
        check("t4b_resp_idx", resp_idx, 2);

        // start during TX is ignored
        clear_model(1'b0, 48'h0, 1'b0);
        issue(6'd0, 32'h0, 1'b0);
        wait_tx_bits("t5_reach20", 20);
        issue(6'd8, 32'h000001AA, 1'b1);
        wait_done("t5_done_seen");
        check("t5_frame", tx_frame, 48'h400000000095);
        check("t5_ticks", tick_cnt, 56);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_crc_cleared", crc_err, 0);

        // reset mid-TX aborts without done
        clear_model(1'b0, 48'h0, 1'b0);
        issue(6'd8, 32'h000001AA, 1'b0);
        wait_tx_bits("t6_reach30", 30);
        rst = 1'b1;
        @(negedge clk);
        check("t6_oe", mmc_cmd_oe, 0);
        check("t6_busy", busy, 0);
        check("t6_cmd_o", mmc_cmd_o, 1);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("t6_no_done", done_cnt, 0);
        clear_model(1'b0, 48'h0, 1'b0);
        issue(6'd0, 32'h0, 1'b0);
        wait_done("t6_done_seen");
        check("t6_frame", tx_frame, 48'h400000000095);
        check("t6_tx_bits", tx_bits, 48);
        check("t6_done_cnt", done_cnt, 1);

        // random clk_done latency
        clear_model(1'b1, 48'h08000001AA13, 1'b1);
        issue(6'd8, 32'h000001AA, 1'b1);
        wait_done("t7_done_seen");
        check("t7_frame", tx_frame, 48'h48000001AA87);
        check("t7_resp", {resp_idx, resp_arg}, {6'd8, 32'h000001AA});
        check("t7_flags", {timeout, crc_err}, 0);
        check("t7_early_ticks", early_ticks, 0);
        check("t7_stable", unstable, 0);
        check("t7_ticks", tick_cnt, 109);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
